// File: rtl/mem_rw_slave_if.sv
// Memory request/response bundle between a test program (master) and the
// RAM slave. The master drives the request; the slave answers with registered
// read data and a one-cycle completion pulse.
interface mem_rw_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  wr;
  logic                  rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  response;

  modport master (
    output wr,
    output rd,
    output addr,
    output wdata,
    input  rdata,
    input  response
  );

  modport slave (
    input  wr,
    input  rd,
    input  addr,
    input  wdata,
    output rdata,
    output response
  );
endinterface

// File: rtl/mem_rw_slave.sv
// Single-port synchronous RAM slave. Word-addressed storage of MEM_SIZE words,
// registered read data (one-cycle latency) and a one-cycle response pulse for
// every accepted request. Simultaneous wr/rd or an out-of-range address is
// ignored: no write, rdata holds, no response.
module mem_rw_slave #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_rw_slave_if.slave      bus
);

  logic [DATA_WIDTH-1:0] mem_r [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  response_r;

  logic                  addr_in_range_s;
  logic                  req_legal_s;
  logic                  wr_accept_s;
  logic                  rd_accept_s;

  // Classify the current request: exactly one of wr/rd and an address inside
  // the storage; anything else is dropped without a response.
  always_comb begin
    addr_in_range_s = 1'b0;
    req_legal_s     = 1'b0;
    wr_accept_s     = 1'b0;
    rd_accept_s     = 1'b0;
    addr_in_range_s = (32'(bus.addr) < 32'(MEM_SIZE));
    req_legal_s     = (bus.wr ^ bus.rd) & addr_in_range_s;
    wr_accept_s     = req_legal_s & bus.wr;
    rd_accept_s     = req_legal_s & bus.rd;
  end

  // Storage, read-data register and response pulse; reset clears everything
  // and drops any request presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      rdata_r    <= {DATA_WIDTH{1'b0}};
      response_r <= 1'b0;
    end else begin
      response_r <= req_legal_s;
      if (wr_accept_s) begin
        mem_r[bus.addr] <= bus.wdata;
      end
      if (rd_accept_s) begin
        rdata_r <= mem_r[bus.addr];
      end
    end
  end

  assign bus.rdata    = rdata_r;
  assign bus.response = response_r;

endmodule

// File: tb/tb_mem_rw_slave.sv
// Directed self-checking bench for mem_rw_slave. Each step drives one request,
// waits for the rising edge, and checks rdata/response 1 ns after it against
// hand-computed values.
module tb_mem_rw_slave;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  mem_rw_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  mem_rw_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_SIZE(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic w, input logic r, input logic [3:0] a,
                     input logic [31:0] d);
    bus.wr    = w;
    bus.rd    = r;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_v;
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    bus.wr     = 1'b0;
    bus.rd     = 1'b0;
    bus.addr   = 4'd0;
    bus.wdata  = 32'd0;

    // 1. reset for two cycles, then read every word
    cyc(1'b0, 1'b0, 4'd0, 32'd0);
    cyc(1'b0, 1'b0, 4'd0, 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_resp", {31'd0, bus.response}, 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b1, 4'(k), 32'd0);
      chk("t1_rdata", bus.rdata, 32'd0);
      chk("t1_resp", {31'd0, bus.response}, 32'd1);
    end

    // 2. write then read same address in consecutive cycles
    cyc(1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
    chk("t2_wr_resp", {31'd0, bus.response}, 32'd1);
    chk("t2_wr_rdata_hold", bus.rdata, 32'd0);
    cyc(1'b0, 1'b1, 4'd3, 32'd0);
    chk("t2_rd_rdata", bus.rdata, 32'hDEADBEEF);
    chk("t2_rd_resp", {31'd0, bus.response}, 32'd1);

    // 3. back-to-back write burst, then back-to-back read burst
    for (int k = 0; k < 16; k++) begin
      exp_v = 32'h11111111 * 32'(k);
      cyc(1'b1, 1'b0, 4'(k), exp_v);
      chk("t3_wr_resp", {31'd0, bus.response}, 32'd1);
      chk("t3_wr_rdata_hold", bus.rdata, 32'hDEADBEEF);
    end
    for (int k = 0; k < 16; k++) begin
      exp_v = 32'h11111111 * 32'(k);
      cyc(1'b0, 1'b1, 4'(k), 32'd0);
      chk("t3_rd_rdata", bus.rdata, exp_v);
      chk("t3_rd_resp", {31'd0, bus.response}, 32'd1);
    end
    chk("t3_last_word", bus.rdata, 32'hFFFFFFFF);

    // 4. simultaneous wr and rd is ignored
    cyc(1'b1, 1'b0, 4'd5, 32'h55);
    chk("t4_wr_resp", {31'd0, bus.response}, 32'd1);
    cyc(1'b0, 1'b1, 4'd2, 32'd0);
    chk("t4_rd2_rdata", bus.rdata, 32'h22222222);
    cyc(1'b1, 1'b1, 4'd5, 32'hFF);
    chk("t4_both_resp", {31'd0, bus.response}, 32'd0);
    chk("t4_both_rdata", bus.rdata, 32'h22222222);
    cyc(1'b0, 1'b1, 4'd5, 32'd0);
    chk("t4_rd5_rdata", bus.rdata, 32'h55);
    chk("t4_rd5_resp", {31'd0, bus.response}, 32'd1);

    // 5. reset mid-stream clears memory, rdata and drops the pending request
    cyc(1'b1, 1'b0, 4'd7, 32'hA5A5A5A5);
    chk("t5_wr_resp", {31'd0, bus.response}, 32'd1);
    cyc(1'b0, 1'b1, 4'd7, 32'd0);
    chk("t5_pre_rdata", bus.rdata, 32'hA5A5A5A5);
    reset = 1'b0;
    cyc(1'b0, 1'b1, 4'd7, 32'd0);
    chk("t5_rst_resp", {31'd0, bus.response}, 32'd0);
    chk("t5_rst_rdata", bus.rdata, 32'd0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 4'd7, 32'd0);
    chk("t5_post_resp", {31'd0, bus.response}, 32'd0);
    cyc(1'b0, 1'b1, 4'd7, 32'd0);
    chk("t5_rd7_rdata", bus.rdata, 32'd0);
    chk("t5_rd7_resp", {31'd0, bus.response}, 32'd1);
    cyc(1'b0, 1'b1, 4'd5, 32'd0);
    chk("t5_rd5_cleared", bus.rdata, 32'd0);

    // 6. idle cycles hold rdata and keep response low
    cyc(1'b1, 1'b0, 4'd9, 32'h1234);
    cyc(1'b0, 1'b1, 4'd9, 32'd0);
    chk("t6_rd_rdata", bus.rdata, 32'h1234);
    chk("t6_rd_resp", {31'd0, bus.response}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 4'd9, 32'hCAFEF00D);
      chk("t6_idle_rdata", bus.rdata, 32'h1234);
      chk("t6_idle_resp", {31'd0, bus.response}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
